// File: rtl/traffic_lane_array_if.sv
// Control, configuration and observation signals of traffic_lane_array.
// The master modport drives the array and the slave modport is the array itself.
interface traffic_lane_array_if #(
    parameter int unsigned LANE_LEN  = 90,
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned STEP_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ROW_W     = 2
);
    logic                 load_en;
    logic                 load_bit;
    logic                 cfg_wrap;
    logic [STEP_W-1:0]    number_of_steps;
    logic                 start;
    logic                 hold;
    logic [NUM_LANES-1:0] inject;
    logic [ROW_W-1:0]     row_sel;
    logic [LANE_LEN-1:0]  row_data;
    logic [STEP_W-1:0]    step;
    logic [CNT_W-1:0]     flow_count;
    logic                 busy;
    logic                 done;

    modport master (
        output load_en, load_bit, cfg_wrap, number_of_steps, start, hold, inject, row_sel,
        input  row_data, step, flow_count, busy, done
    );

    modport slave (
        input  load_en, load_bit, cfg_wrap, number_of_steps, start, hold, inject, row_sel,
        output row_data, step, flow_count, busy, done
    );
endinterface

// File: rtl/traffic_lane_array.sv
// Multi-lane rule-184 traffic automaton with a serial load chain, run control and row readout.
// Define TRAFFIC_FLOW_COUNT_EN to build the exit-flow counter; otherwise flow_count is 0.
module traffic_lane_array #(
    parameter int unsigned LANE_LEN  = 90,
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned STEP_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ROW_W     = 2
) (
    input logic                 clk,
    input logic                 rst,
    traffic_lane_array_if.slave bus
);
    localparam int unsigned NCELLS = NUM_LANES * LANE_LEN;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q;
    logic [NCELLS-1:0] cells_q;
    logic [NCELLS-1:0] cells_next;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_inc;
    logic              wrap_q;
    logic              idle_like;
    logic              load_go;
    logic              start_go;
    logic              upd;

    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign load_go   = idle_like && bus.load_en;
    assign start_go  = idle_like && !bus.load_en && bus.start;
    assign upd       = (state_q == StRun) && !bus.hold;
    assign step_inc  = step_q + STEP_W'(1);

`ifdef TRAFFIC_FLOW_COUNT_EN
    logic [NUM_LANES-1:0] exit_car;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int unsigned Base = g * LANE_LEN;
        logic [LANE_LEN-1:0] cur;
        logic [LANE_LEN-1:0] lft;
        logic [LANE_LEN-1:0] rgt;

        assign cur = cells_q[Base +: LANE_LEN];
        // Open boundary: inflow enters at pos 0, the exit past the last cell is always free.
        assign lft = {cur[LANE_LEN-2:0], wrap_q ? cur[LANE_LEN-1] : bus.inject[g]};
        assign rgt = {wrap_q & cur[0], cur[LANE_LEN-1:1]};
        assign cells_next[Base +: LANE_LEN] = (cur & rgt) | (~cur & lft);
`ifdef TRAFFIC_FLOW_COUNT_EN
        assign exit_car[g] = cur[LANE_LEN-1] & ~rgt[LANE_LEN-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cells_q <= '0;
            step_q  <= '0;
            wrap_q  <= 1'b0;
        end else if (load_go) begin
            cells_q <= {cells_q[NCELLS-2:0], bus.load_bit};
            state_q <= StIdle;
        end else if (start_go) begin
            step_q  <= '0;
            wrap_q  <= bus.cfg_wrap;
            state_q <= (bus.number_of_steps == '0) ? StDone : StRun;
        end else if (upd) begin
            cells_q <= cells_next;
            step_q  <= step_inc;
            if (step_inc == bus.number_of_steps) begin
                state_q <= StDone;
            end
        end else if (state_q == 2'd3) begin
            state_q <= StIdle;
        end
    end

`ifdef TRAFFIC_FLOW_COUNT_EN
    logic [CNT_W-1:0] flow_q;
    logic [CNT_W:0]   flow_sum;

    always_comb begin
        flow_sum = {1'b0, flow_q};
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            flow_sum = flow_sum + (CNT_W + 1)'(exit_car[lane]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            flow_q <= '0;
        end else if (upd) begin
            flow_q <= flow_sum[CNT_W] ? '1 : flow_sum[CNT_W-1:0];
        end
    end

    assign bus.flow_count = flow_q;
`else
    assign bus.flow_count = '0;
`endif

    always_comb begin
        bus.row_data = '0;
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            if (bus.row_sel == ROW_W'(lane)) begin
                bus.row_data = cells_q[lane * LANE_LEN +: LANE_LEN];
            end
        end
    end

    assign bus.step = step_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
endmodule

// File: doc/traffic_lane_array.md
Name: traffic_lane_array

Overview:
- Self-contained, multi-lane rule-184 traffic cellular automaton.
- NUM_LANES independent lanes of LANE_LEN one-bit cells; all cells update synchronously once per enabled step.
- Adds selectable periodic or open boundaries, per-lane car injection, pause and start/restart control.
- Exit-flow statistics and row readout replace simulation-only file dumps, so the array is observable in hardware.

Parameters:
- LANE_LEN, 90: cells per lane (≥2).
- NUM_LANES, 3: number of lanes (≥1).
- STEP_W, 32: width of step counter and step target.
- CNT_W, 16: width of the flow counter.
- ROW_W, 2: width of row_sel (2^ROW_W ≥ NUM_LANES).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_en  in  1  shift load_bit into the cell chain (IDLE/DONE only).
- load_bit  in  1  serial initial cell value.
- cfg_wrap  in  1  1 = periodic boundary, 0 = open boundary; sampled on start.
- number_of_steps  in  STEP_W  updates to perform per run.
- start  in  1  begin a run (IDLE/DONE).
- hold  in  1  pause updates while RUN.
- inject  in  NUM_LANES  open-mode inflow request per lane.
- row_sel  in  ROW_W  lane selected for readout.
- row_data  out  LANE_LEN  cells of the selected lane; bit p = position p.
- step  out  STEP_W  completed updates this run.
- flow_count  out  CNT_W  cars that crossed the right edge this run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=1 at posedge, any state including mid-run):
  - all cells 0, state IDLE, step 0, flow_count 0, busy 0, done 0, latched wrap 0.
  - rst overrides every other input.
- Cell index: i = lane*LANE_LEN + pos.
- Loading: load_en=1 in IDLE or DONE does the following each cycle:
  - cell[0] ← load_bit; cell[i+1] ← cell[i] across the whole flattened array.
  - The last bit shifted in lands at index 0.
  - A full load takes NUM_LANES*LANE_LEN cycles.
  - load_en in DONE returns to IDLE and clears done.
  - load_en has priority over start in the same cycle.
  - load_en is ignored in RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start (load_en=0): step←0, flow_count←0, wrap latched from cfg_wrap.
    - If number_of_steps==0, go to DONE (done=1 next cycle) with cells untouched.
    - Otherwise go to RUN (busy=1 next cycle).
  - RUN, hold=1: cells, step and flow_count frozen; state stays RUN.
  - RUN, hold=0: one update per cycle; step←step+1.
    - When the new step equals number_of_steps: go to DONE; done=1 and busy=0 in the same cycle that step shows the final value.
  - DONE: holds cells, step and flow_count until start, load_en or rst.
  - number_of_steps is sampled every RUN cycle; the team requires it stable during a run.
- Update rule, per lane, with L = left neighbour and R = right neighbour:
  - next = (cur & R) | (~cur & L).
  - Interior cells: L = pos-1, R = pos+1.
  - pos 0: L = pos LANE_LEN-1 if wrap, else inject[lane].
  - pos LANE_LEN-1: R = pos 0 if wrap, else 0 (exit always free).
  - Lanes never interact.
- Flow: on each update, count lanes with cur[LANE_LEN-1]=1 and R=0.
  - Add that count to flow_count, saturating at 2^CNT_W-1.
- Readout: row_data is a combinational view of lane row_sel; row_sel ≥ NUM_LANES gives 0.

Optional Feature:
- Macro TRAFFIC_FLOW_COUNT_EN.
- Defined: flow_count is implemented as specified.
- Undefined: flow counter logic is omitted and flow_count is constant 0; all other behaviour is identical.

Test Plan:
- Wrap, single car: load 269 zeros then a 1 (car at lane0 pos0), cfg_wrap=1, number_of_steps=90, start.
  - Done after 90 RUN cycles; step=90; row_sel=0 gives row_data bit0=1 only; flow_count=1.
- Jam: load all 270 ones, cfg_wrap=1, number_of_steps=5.
  - Done with step=5; every row_data all ones; flow_count=0.
- Open-mode inflow: empty array, cfg_wrap=0, inject=3'b010 held, number_of_steps=10.
  - row_sel=1: bits 1,3,5,7,9 set, others 0.
  - Lanes 0 and 2 all zero; flow_count=0.
- Zero steps: number_of_steps=0, start.
  - done=1 on the following cycle; step=0; busy never asserts; cells unchanged.
- Pause: single-car wrap load, number_of_steps=4, hold=1 for 3 cycles after step=2.
  - done arrives 7 cycles after start instead of 4; final step=4; car at pos4.
- Reset mid-run: assert rst when step=2.
  - Next cycle: step=0, busy=0, done=0, all row_data 0, flow_count=0; a later start with no load finishes with all zeros.
